// File: rtl/tt_um_jleugeri_ttt_token_tally.sv
// Token tally: scans processor slots one step at a time, tracks which slots are
// active, and reports per-scan good/bad token totals on each scan wrap.
module tt_um_jleugeri_ttt_token_tally #(
    parameter int NUM_PROCESSORS = 10,
    parameter int NEW_TOKEN_BITS = 8
) (
    input  logic                              clock,
    input  logic                              reset_n,
    input  logic                              step,
    input  logic [1:0]                        token_startstop,
    input  logic                              prog_we,
    input  logic [$clog2(NUM_PROCESSORS)-1:0] prog_id,
    input  logic                              prog_sign,
    output logic [$clog2(NUM_PROCESSORS)-1:0] processor_id,
    output logic [NEW_TOKEN_BITS-1:0]         new_good_tokens,
    output logic [NEW_TOKEN_BITS-1:0]         new_bad_tokens,
    output logic                              scan_done,
    output logic                              protocol_error
);

    localparam int ID_W = $clog2(NUM_PROCESSORS);
    localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_PROCESSORS - 1);
    localparam logic [NEW_TOKEN_BITS-1:0] ACC_MAX = '1;

    logic [NUM_PROCESSORS-1:0] active_reg;
    logic [NUM_PROCESSORS-1:0] sign_reg;

    logic [ID_W-1:0]           processor_id_reg, processor_id_next;
    logic [NEW_TOKEN_BITS-1:0] good_acc_reg, good_acc_next;
    logic [NEW_TOKEN_BITS-1:0] bad_acc_reg, bad_acc_next;
    logic [NEW_TOKEN_BITS-1:0] new_good_reg, new_good_next;
    logic [NEW_TOKEN_BITS-1:0] new_bad_reg, new_bad_next;
    logic                      scan_done_reg, scan_done_next;
    logic                      protocol_error_reg, protocol_error_next;

    logic                      slot_active_next;
    logic                      slot_sign;
    logic                      wrap;
    logic [NEW_TOKEN_BITS-1:0] good_sum;
    logic [NEW_TOKEN_BITS-1:0] bad_sum;

    function automatic logic [NEW_TOKEN_BITS-1:0] sat_inc(
        input logic [NEW_TOKEN_BITS-1:0] value,
        input logic                      inc
    );
        if (inc && value != ACC_MAX) begin
            return value + 1'b1;
        end
        return value;
    endfunction

    always_comb begin
        slot_sign = sign_reg[processor_id_reg];
        case (token_startstop)
            2'b10:   slot_active_next = 1'b1;
            2'b01:   slot_active_next = 1'b0;
            default: slot_active_next = active_reg[processor_id_reg];
        endcase

        wrap     = step && (processor_id_reg == LAST_ID);
        // sign_reg still holds the pre-write value here, so a same-cycle
        // program of this slot only takes effect from the next visit.
        good_sum = sat_inc(good_acc_reg, step && slot_active_next && !slot_sign);
        bad_sum  = sat_inc(bad_acc_reg, step && slot_active_next && slot_sign);

        processor_id_next   = processor_id_reg;
        good_acc_next       = good_acc_reg;
        bad_acc_next        = bad_acc_reg;
        new_good_next       = new_good_reg;
        new_bad_next        = new_bad_reg;
        scan_done_next      = 1'b0;
        protocol_error_next = protocol_error_reg;

        if (step) begin
            if (token_startstop == 2'b11) begin
                protocol_error_next = 1'b1;
            end
            if (wrap) begin
                processor_id_next = '0;
                new_good_next     = good_sum;
                new_bad_next      = bad_sum;
                good_acc_next     = '0;
                bad_acc_next      = '0;
                scan_done_next    = 1'b1;
            end else begin
                processor_id_next = processor_id_reg + 1'b1;
                good_acc_next     = good_sum;
                bad_acc_next      = bad_sum;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            processor_id_reg   <= '0;
            good_acc_reg       <= '0;
            bad_acc_reg        <= '0;
            new_good_reg       <= '0;
            new_bad_reg        <= '0;
            scan_done_reg      <= 1'b0;
            protocol_error_reg <= 1'b0;
        end else begin
            processor_id_reg   <= processor_id_next;
            good_acc_reg       <= good_acc_next;
            bad_acc_reg        <= bad_acc_next;
            new_good_reg       <= new_good_next;
            new_bad_reg        <= new_bad_next;
            scan_done_reg      <= scan_done_next;
            protocol_error_reg <= protocol_error_next;
        end
    end

    // Per-slot flags; an out-of-range prog_id matches no slot and is dropped.
    generate
        for (genvar gi = 0; gi < NUM_PROCESSORS; gi++) begin : g_slot
            logic active_bit_reg;
            logic sign_bit_reg;

            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    active_bit_reg <= 1'b0;
                    sign_bit_reg   <= 1'b0;
                end else begin
                    if (step && processor_id_reg == ID_W'(gi)) begin
                        active_bit_reg <= slot_active_next;
                    end
                    if (prog_we && prog_id == ID_W'(gi)) begin
                        sign_bit_reg <= prog_sign;
                    end
                end
            end

            assign active_reg[gi] = active_bit_reg;
            assign sign_reg[gi]   = sign_bit_reg;
        end
    endgenerate

    assign processor_id    = processor_id_reg;
    assign new_good_tokens = new_good_reg;
    assign new_bad_tokens  = new_bad_reg;
    assign scan_done       = scan_done_reg;
    assign protocol_error  = protocol_error_reg;

endmodule

// File: tb/tb_tt_um_jleugeri_ttt_token_tally.sv
// Bench for the token tally: table-driven scans, a mid-scan reset sequence and
// random traffic, all checked against a slot-level behavioural model.
module tb_tt_um_jleugeri_ttt_token_tally;

    localparam int N = 10;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       step = 1'b0;
    logic [1:0] token_startstop = 2'b00;
    logic       prog_we = 1'b0;
    logic [3:0] prog_id = 4'd0;
    logic       prog_sign = 1'b0;

    logic [3:0] processor_id, processor_id2;
    logic [7:0] new_good_tokens, new_bad_tokens;
    logic [1:0] new_good_tokens2, new_bad_tokens2;
    logic       scan_done, scan_done2, protocol_error, protocol_error2;

    tt_um_jleugeri_ttt_token_tally #(.NUM_PROCESSORS(N), .NEW_TOKEN_BITS(8)) dut (
        .clock(clock), .reset_n(reset_n), .step(step),
        .token_startstop(token_startstop), .prog_we(prog_we),
        .prog_id(prog_id), .prog_sign(prog_sign),
        .processor_id(processor_id), .new_good_tokens(new_good_tokens),
        .new_bad_tokens(new_bad_tokens), .scan_done(scan_done),
        .protocol_error(protocol_error)
    );

    tt_um_jleugeri_ttt_token_tally #(.NUM_PROCESSORS(N), .NEW_TOKEN_BITS(2)) dut2 (
        .clock(clock), .reset_n(reset_n), .step(step),
        .token_startstop(token_startstop), .prog_we(prog_we),
        .prog_id(prog_id), .prog_sign(prog_sign),
        .processor_id(processor_id2), .new_good_tokens(new_good_tokens2),
        .new_bad_tokens(new_bad_tokens2), .scan_done(scan_done2),
        .protocol_error(protocol_error2)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail = 0;

    // Reference model: per-slot flags and plain integer counts for the scan.
    bit m_act [N];
    bit m_sign [N];
    int m_pid, m_good, m_bad, m_out_good, m_out_bad;
    bit m_done, m_err;

    typedef struct {
        logic [N-1:0] start_mask;
        logic [N-1:0] stop_mask;
        logic [N-1:0] illegal_mask;
        bit           prog_en;
        logic [3:0]   prog_id;
        bit           prog_sign;
        int           exp_good;
        int           exp_bad;
        int           exp_good2;
        int           exp_bad2;
        bit           exp_err;
    } scan_vec_t;

    scan_vec_t tbl [10];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sat(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_act[i]  = 1'b0;
            m_sign[i] = 1'b0;
        end
        m_pid = 0; m_good = 0; m_bad = 0; m_out_good = 0; m_out_bad = 0;
        m_done = 1'b0; m_err = 1'b0;
    endtask

    task automatic model_edge(input bit st, input logic [1:0] ts, input bit we,
                              input logic [3:0] pid, input bit sg);
        m_done = 1'b0;
        if (st) begin
            if (ts == 2'b10) m_act[m_pid] = 1'b1;
            else if (ts == 2'b01) m_act[m_pid] = 1'b0;
            if (ts == 2'b11) m_err = 1'b1;
            if (m_act[m_pid]) begin
                if (m_sign[m_pid]) m_bad++;
                else m_good++;
            end
            if (m_pid == N - 1) begin
                m_out_good = m_good;
                m_out_bad  = m_bad;
                m_good = 0;
                m_bad  = 0;
                m_pid  = 0;
                m_done = 1'b1;
            end else begin
                m_pid++;
            end
        end
        if (we && pid < N) m_sign[pid] = sg;
    endtask

    task automatic check_all();
        check("processor_id", processor_id, m_pid);
        check("new_good", new_good_tokens, sat(m_out_good, 255));
        check("new_bad", new_bad_tokens, sat(m_out_bad, 255));
        check("scan_done", scan_done, m_done);
        check("protocol_error", protocol_error, m_err);
        check("processor_id2", processor_id2, m_pid);
        check("new_good2", new_good_tokens2, sat(m_out_good, 3));
        check("new_bad2", new_bad_tokens2, sat(m_out_bad, 3));
        check("scan_done2", scan_done2, m_done);
    endtask

    task automatic cycle(input bit st, input logic [1:0] ts, input bit we,
                         input logic [3:0] pid, input bit sg);
        step = st; token_startstop = ts; prog_we = we; prog_id = pid; prog_sign = sg;
        @(posedge clock);
        model_edge(st, ts, we, pid, sg);
        #1;
        $display("cyc step=%0b ts=%b we=%0b pid=%0d sg=%0b -> id=%0d good=%0d bad=%0d done=%0b err=%0b",
                 st, ts, we, pid, sg, processor_id, new_good_tokens, new_bad_tokens,
                 scan_done, protocol_error);
        check_all();
    endtask

    task automatic check_reset_zero(input string tag);
        check({tag, "_id"}, processor_id, 0);
        check({tag, "_good"}, new_good_tokens, 0);
        check({tag, "_bad"}, new_bad_tokens, 0);
        check({tag, "_done"}, scan_done, 0);
        check({tag, "_err"}, protocol_error, 0);
        check({tag, "_good2"}, new_good_tokens2, 0);
    endtask

    initial begin
        tbl[0] = '{10'h000, 10'h000, 10'h000, 0, 4'd0,  0, 0, 0, 0, 0, 0};
        tbl[1] = '{10'h0A4, 10'h000, 10'h000, 0, 4'd0,  0, 3, 0, 3, 0, 0};
        tbl[2] = '{10'h000, 10'h000, 10'h000, 0, 4'd0,  0, 3, 0, 3, 0, 0};
        tbl[3] = '{10'h000, 10'h020, 10'h000, 0, 4'd0,  0, 2, 0, 2, 0, 0};
        tbl[4] = '{10'h020, 10'h000, 10'h000, 1, 4'd5,  1, 2, 1, 2, 1, 0};
        tbl[5] = '{10'h000, 10'h000, 10'h000, 1, 4'd12, 0, 2, 1, 2, 1, 0};
        tbl[6] = '{10'h010, 10'h000, 10'h000, 0, 4'd0,  0, 3, 1, 3, 1, 0};
        tbl[7] = '{10'h000, 10'h000, 10'h010, 0, 4'd0,  0, 3, 1, 3, 1, 1};
        tbl[8] = '{10'h000, 10'h000, 10'h000, 0, 4'd0,  0, 3, 1, 3, 1, 1};
        tbl[9] = '{10'h3FF, 10'h000, 10'h000, 0, 4'd0,  0, 9, 1, 3, 1, 1};

        model_reset();
        reset_n = 1'b0;
        #12;
        check_reset_zero("reset");
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        for (int r = 0; r < 10; r++) begin
            if (tbl[r].prog_en) cycle(1'b0, 2'b00, 1'b1, tbl[r].prog_id, tbl[r].prog_sign);
            for (int s = 0; s < N; s++) begin
                logic [1:0] ts;
                if (tbl[r].start_mask[s]) ts = 2'b10;
                else if (tbl[r].stop_mask[s]) ts = 2'b01;
                else if (tbl[r].illegal_mask[s]) ts = 2'b11;
                else ts = 2'b00;
                if (s % 3 == 1) cycle(1'b0, 2'($urandom_range(0, 3)), 1'b0, 4'd0, 1'b0);
                cycle(1'b1, ts, 1'b0, 4'd0, 1'b0);
            end
            check("tbl_good", new_good_tokens, tbl[r].exp_good);
            check("tbl_bad", new_bad_tokens, tbl[r].exp_bad);
            check("tbl_good2", new_good_tokens2, tbl[r].exp_good2);
            check("tbl_bad2", new_bad_tokens2, tbl[r].exp_bad2);
            check("tbl_err", protocol_error, tbl[r].exp_err);
            check("tbl_done", scan_done, 1);
            cycle(1'b0, 2'b00, 1'b0, 4'd0, 1'b0);
            check("totals_hold", new_good_tokens, tbl[r].exp_good);
        end

        // Reset asserted away from a clock edge while sitting at slot 6.
        for (int s = 0; s < 6; s++) cycle(1'b1, 2'b00, 1'b0, 4'd0, 1'b0);
        check("pre_reset_id", processor_id, 6);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_zero("async_reset");
        model_reset();
        @(negedge clock);
        reset_n = 1'b1;
        for (int s = 0; s < N; s++) cycle(1'b1, (s == 1) ? 2'b10 : 2'b00, 1'b0, 4'd0, 1'b0);
        check("post_reset_good", new_good_tokens, 1);
        check("post_reset_bad", new_bad_tokens, 0);

        for (int i = 0; i < 600; i++) begin
            logic [1:0] ts;
            ts = ($urandom_range(0, 31) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            cycle($urandom_range(0, 3) != 0, ts, $urandom_range(0, 3) == 0,
                  4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
